spi_controller: RTL and testbench

SPI initiator (mode 0, CPOL=0/CPHA=0) that drives nCS/SCLK/COPI frames into the existing SPI register peripheral (ui_in[2:0] pins).
- Accepts one register transaction per valid/ready handshake and serialises it as a 16-bit MSB-first frame.
- Used as the bench/companion driver and as the host-side block for chip-to-chip register configuration.

---
 rtl/spi_controller.sv | 188 ++++++++++++++++++
 tb/tb_spi_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one {rw, addr[6:0], wdata[7:0]} frame per valid/ready handshake, MSB first.
// Define SPI_CTRL_READ_EN to add the CIPO input and the rdata capture for read frames.
`timescale 1ns/1ps
module spi_controller #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       busy,
   output logic       done,
   output logic       nCS,
   output logic       SCLK,
   output logic       COPI
`ifdef SPI_CTRL_READ_EN
   ,
   input  logic       CIPO,
   output logic [7:0] rdata
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_HI    = 3'd2;
   localparam logic [2:0] S_LO    = 3'd3;
   localparam logic [2:0] S_TRAIL = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] frame_q, frame_d;
   logic        ncs_q, ncs_d;
   logic        sclk_q, sclk_d;
   logic        done_q, done_d;
   logic        phase_end;

`ifdef SPI_CTRL_READ_EN
   logic        rw_q, rw_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  rdata_q, rdata_d;
`endif

   assign phase_end = (div_q == 8'd0);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      ncs_d   = ncs_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;
`ifdef SPI_CTRL_READ_EN
      rw_d    = rw_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_LEAD;
               div_d   = DIV_RELOAD;
               bit_d   = 4'd15;
               frame_d = {req_rw, req_addr, req_wdata};
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
`ifdef SPI_CTRL_READ_EN
               rw_d    = req_rw;
               rx_d    = 8'h00;
`endif
            end
         end
         S_LEAD, S_LO: begin
            if (phase_end) begin
               state_d = S_HI;
               div_d   = DIV_RELOAD;
               sclk_d  = 1'b1;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_HI: begin
            if (phase_end) begin
               div_d  = DIV_RELOAD;
               sclk_d = 1'b0;
`ifdef SPI_CTRL_READ_EN
               // HI phases 9..16 carry the peripheral's read byte, MSB first
               if (!rw_q && (bit_q < 4'd8)) begin
                  rx_d = {rx_q[6:0], CIPO};
               end
`endif
               if (bit_q == 4'd0) begin
                  state_d = S_TRAIL;
               end else begin
                  state_d = S_LO;
                  bit_d   = bit_q - 4'd1;
                  frame_d = {frame_q[14:0], 1'b0};
               end
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_TRAIL: begin
            if (phase_end) begin
               state_d = S_GAP;
               div_d   = GAP_RELOAD;
               ncs_d   = 1'b1;
               frame_d = 16'h0000;
               done_d  = 1'b1;
`ifdef SPI_CTRL_READ_EN
               if (!rw_q) begin
                  rdata_d = rx_q;
               end
`endif
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_GAP: begin
            if (phase_end) begin
               state_d = S_IDLE;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ncs_d   = 1'b1;
            sclk_d  = 1'b0;
            frame_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         bit_q   <= 4'd0;
         frame_q <= 16'h0000;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
      end
   end

`ifdef SPI_CTRL_READ_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_q    <= 1'b0;
         rx_q    <= 8'h00;
         rdata_q <= 8'h00;
      end else begin
         rw_q    <= rw_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
`endif

   // COPI comes straight from the shift register MSB, which is cleared whenever nCS is high
   assign COPI      = frame_q[15];
   assign nCS       = ncs_q;
   assign SCLK      = sclk_q;
   assign done      = done_q;
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: frames decoded at SCLK rises and compared with {rw, addr, wdata} and the frame timing rules.
`timescale 1ns/1ps
module tb_spi_controller;
   localparam int CLK_DIV      = 4;
   localparam int GAP_CYCLES   = 2;
   localparam int LOW_CYC      = 33 * CLK_DIV;
   localparam int FRAME_BUDGET = 40 * CLK_DIV + GAP_CYCLES + 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [6:0] req_addr = 7'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       busy, done, nCS, SCLK, COPI;
`ifdef SPI_CTRL_READ_EN
   logic       CIPO;
   logic [7:0] rdata;
`endif
   logic [7:0] resp_byte = 8'h00;
   logic [7:0] exp_rdata = 8'h00;

   always #5 clk = ~clk;

   spi_controller #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .nCS(nCS), .SCLK(SCLK), .COPI(COPI)
`ifdef SPI_CTRL_READ_EN
      , .CIPO(CIPO), .rdata(rdata)
`endif
   );

   typedef struct {
      logic [15:0] word;
      int          low;
      int          edges;
      logic        done_seen;
      int          gap;
      logic [7:0]  rd;
   } frame_t;

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic [15:0] exp_word;
   } vec_t;

   frame_t     frames[$];
   logic [7:0] periph_regs [0:127];
   int         checks = 0;
   int         failures = 0;
   int         cur_edges = 0;
   int         aborts = 0;

   // monitor state
   logic        prev_ncs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic [15:0] mon_word = 16'h0;
   int          mon_low = 0;
   int          mon_cyc = 0;
   int          mon_rise_cyc = 0;
   int          mon_gap = 0;
   logic        mon_aborted = 1'b0;

`ifdef SPI_CTRL_READ_EN
   // Peripheral drives read bit (16-k) during HI phase k for k = 9..16
   always_comb begin
      CIPO = 1'b0;
      if (cur_edges >= 9 && cur_edges <= 16) CIPO = resp_byte[3'(16 - cur_edges)];
   end
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timed_out(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (nCS === 1'b0) begin
            if (prev_ncs === 1'b1) begin
               mon_low = 0; cur_edges = 0; mon_word = 16'h0; mon_aborted = 1'b0;
               mon_gap = mon_cyc - mon_rise_cyc;
            end
            mon_low++;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
               mon_word = {mon_word[14:0], COPI};
               cur_edges++;
            end
            if (rst_n === 1'b0) mon_aborted = 1'b1;
         end
         if (done === 1'b1 && !(nCS === 1'b1 && prev_ncs === 1'b0 && !mon_aborted)) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: done=1 at cycle %0d outside a frame end", mon_cyc);
         end
         if (nCS === 1'b1 && prev_ncs === 1'b0) begin
            if (mon_aborted) begin
               aborts++;
            end else begin
               frame_t f;
               f.word = mon_word; f.low = mon_low; f.edges = cur_edges;
               f.done_seen = done; f.gap = mon_gap;
`ifdef SPI_CTRL_READ_EN
               f.rd = rdata;
`else
               f.rd = 8'h00;
`endif
               frames.push_back(f);
               if (mon_word[15]) periph_regs[mon_word[14:8]] = mon_word[7:0];
            end
            mon_rise_cyc = mon_cyc;
            cur_edges = 0;
         end
         prev_ncs = nCS;
         prev_sclk = SCLK;
      end
   end

   // Present a request at posedge+1 and return one cycle after it is accepted.
   task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wd, input bit scramble);
      int n = 0;
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
      while (req_ready !== 1'b1 && n < FRAME_BUDGET) begin step(); n++; end
      if (req_ready !== 1'b1) timed_out("accept");
      step();
      req_valid = 1'b0;
      check("accept_ncs_low", 32'(nCS), 32'(0));
      check("accept_busy", 32'(busy), 32'(1));
      check("accept_ready_low", 32'(req_ready), 32'(0));
      if (scramble) begin
         n = 0;
         while (busy === 1'b1 && n < FRAME_BUDGET) begin
            req_rw = 1'($urandom); req_addr = 7'($urandom); req_wdata = 8'($urandom);
            step(); n++;
         end
      end
   endtask

   task automatic expect_frame(input string name, input logic [15:0] exp_word, output frame_t f);
      int n = 0;
      f = '{default: 0};
      while (frames.size() == 0 && n < FRAME_BUDGET) begin step(); n++; end
      if (frames.size() == 0) begin
         timed_out({name, "_frame"});
      end else begin
         f = frames.pop_front();
         check({name, "_word"}, 32'(f.word), 32'(exp_word));
         check({name, "_ncs_low_cycles"}, 32'(f.low), 32'(LOW_CYC));
         check({name, "_sclk_rises"}, 32'(f.edges), 32'(16));
         check({name, "_done"}, 32'(f.done_seen), 32'(1));
`ifdef SPI_CTRL_READ_EN
         check({name, "_rdata"}, 32'(f.rd), 32'(exp_rdata));
`endif
      end
   endtask

   task automatic run_frame(input string name, input logic rw, input logic [6:0] addr,
                            input logic [7:0] wd, input bit scramble);
      frame_t f;
      issue(rw, addr, wd, scramble);
`ifdef SPI_CTRL_READ_EN
      if (!rw) exp_rdata = resp_byte;
`endif
      expect_frame(name, {rw, addr, wd}, f);
   endtask

   initial begin
      vec_t   vecs[9];
      frame_t fa, fb;
      int     n;

      vecs[0] = '{1'b1, 7'h01, 8'h55, 16'h8155};
      vecs[1] = '{1'b1, 7'h02, 8'hAA, 16'h82AA};
      vecs[2] = '{1'b0, 7'h7F, 8'h00, 16'h7F00};
      vecs[3] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF};
      vecs[4] = '{1'b0, 7'h00, 8'h00, 16'h0000};
      vecs[5] = '{1'b1, 7'h00, 8'hF0, 16'h80F0};
      vecs[6] = '{1'b1, 7'h00, 8'hFF, 16'h80FF};
      vecs[7] = '{1'b1, 7'h02, 8'hFF, 16'h82FF};
      vecs[8] = '{1'b1, 7'h04, 8'h80, 16'h8480};

      // reset state
      repeat (3) step();
      check("rst_ncs", 32'(nCS), 32'(1));
      check("rst_sclk", 32'(SCLK), 32'(0));
      check("rst_copi", 32'(COPI), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
`ifdef SPI_CTRL_READ_EN
      check("rst_rdata", 32'(rdata), 32'(0));
`endif
      rst_n = 1'b1;
      step();
      check("rst_ready", 32'(req_ready), 32'(1));

      // table-driven frames
      foreach (vecs[i]) begin
         frame_t f;
         resp_byte = 8'($urandom);
         issue(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0);
`ifdef SPI_CTRL_READ_EN
         if (!vecs[i].rw) exp_rdata = resp_byte;
`endif
         expect_frame($sformatf("vec%0d", i), vecs[i].exp_word, f);
         repeat (2) step();
      end
      check("periph_reg00", 32'(periph_regs[0]), 32'(8'hFF));
      check("periph_reg02", 32'(periph_regs[2]), 32'(8'hFF));
      check("periph_reg04", 32'(periph_regs[4]), 32'(8'h80));

      // back-to-back with req_valid held: second nCS fall GAP_CYCLES+1 after first rise
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h01; req_wdata = 8'h55;
      n = 0;
      while (req_ready !== 1'b1 && n < FRAME_BUDGET) begin step(); n++; end
      step();
      req_addr = 7'h02; req_wdata = 8'hAA;
      n = 0;
      while (req_ready !== 1'b1 && n < FRAME_BUDGET) begin step(); n++; end
      if (req_ready !== 1'b1) timed_out("b2b_ready");
      step();
      req_valid = 1'b0;
      check("b2b_second_accept", 32'(nCS), 32'(0));
      expect_frame("b2b_a", 16'h8155, fa);
      expect_frame("b2b_b", 16'h82AA, fb);
      check("b2b_gap", 32'(fb.gap), 32'(GAP_CYCLES + 1));

      // inputs scrambled every cycle while busy
      run_frame("scramble", 1'b1, 7'h33, 8'hC3, 1'b1);
      repeat (FRAME_BUDGET / 2) step();
      check("scramble_no_extra", 32'(frames.size()), 32'(0));

      // reset while bit 7 is on the wire
      issue(1'b1, 7'h15, 8'h3C, 1'b0);
      n = 0;
      while (cur_edges < 9 && n < FRAME_BUDGET) begin step(); n++; end
      if (cur_edges < 9) timed_out("abort_reach_bit7");
      rst_n = 1'b0;
      step();
      check("abort_ncs", 32'(nCS), 32'(1));
      check("abort_sclk", 32'(SCLK), 32'(0));
      check("abort_copi", 32'(COPI), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
`ifdef SPI_CTRL_READ_EN
      exp_rdata = 8'h00;
`endif
      repeat (FRAME_BUDGET / 2) step();
      check("abort_no_frame", 32'(frames.size()), 32'(0));
      check("abort_seen", 32'(aborts), 32'(1));
      run_frame("after_abort", 1'b1, 7'h15, 8'h3C, 1'b0);

`ifdef SPI_CTRL_READ_EN
      resp_byte = 8'hA5;
      run_frame("read_a5", 1'b0, 7'h04, 8'h00, 1'b0);
      resp_byte = 8'h5A;
      run_frame("write_keeps_rdata", 1'b1, 7'h04, 8'h11, 1'b0);
      check("rdata_hold", 32'(rdata), 32'(8'hA5));
`endif

      // randomized frames against the word/timing model
      for (int k = 0; k < 24; k++) begin
         resp_byte = 8'($urandom);
         run_frame($sformatf("rand%0d", k), 1'($urandom), 7'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 5)) step();
      end

      repeat (FRAME_BUDGET / 2) step();
      check("final_no_extra", 32'(frames.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
